stack_round_ctrl: RTL and testbench

- Per-block round sequencer for the stacking game. It spawns each block with a colour, waits for the player's drop, and resolves the landing as a hit, a miss or a timeout.
- On a hit it emits the one-cycle collision pulse and colour consumed by the score datapath; on a miss or timeout it decrements lives.
- It tracks stack height and lives, and declares game over.
- It sits between the input debouncer/physics tick and the score, spawner and display blocks.

---
 rtl/stack_pkg.sv | 30 +++
 rtl/stack_round_ctrl_if.sv | 28 ++
 rtl/stack_timer.sv | 36 +++
 rtl/stack_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_stack_round_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared types and constants for the stacking-game round sequencer.
package stack_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSpawn  = 3'd1,
    StSwing  = 3'd2,
    StDrop   = 3'd3,
    StScore  = 3'd4,
    StSettle = 3'd5,
    StOver   = 3'd6
  } state_e;

  typedef logic [1:0] color_t;

  localparam color_t COL_NONE = 2'b00;
  localparam color_t COL_A    = 2'b01;
  localparam color_t COL_B    = 2'b10;
  localparam color_t COL_C    = 2'b11;

  localparam int unsigned DEF_LIVES        = 3;
  localparam int unsigned DEF_MAX_HEIGHT   = 100;
  localparam int unsigned DEF_DROP_TIMEOUT = 255;

  // Colour sequence skips COL_NONE so a spawned block always has a colour.
  function automatic color_t rotate_color(input color_t c);
    return (c == COL_C) ? COL_A : color_t'(c + 2'd1);
  endfunction

endpackage

// File: rtl/stack_round_ctrl_if.sv
// Handshake bundle between the round sequencer and its game neighbours.
interface stack_round_ctrl_if;
  import stack_pkg::*;

  logic       start;
  logic       drop_btn;
  logic       tick;
  logic       land_hit;
  logic       land_miss;
  logic       spawn;
  logic       collision;
  color_t     color;
  logic [1:0] lives;
  logic [6:0] height;
  logic       game_over;
  logic       win;

  modport master (
    output start, drop_btn, tick, land_hit, land_miss,
    input  spawn, collision, color, lives, height, game_over, win
  );

  modport slave (
    input  start, drop_btn, tick, land_hit, land_miss,
    output spawn, collision, color, lives, height, game_over, win
  );

endinterface

// File: rtl/stack_timer.sv
// Loadable down-counter; stops at zero, done is high while the count is zero.
module stack_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/stack_round_ctrl.sv
// Per-block round sequencer: spawn, swing, drop, resolve hit/miss/timeout, track lives/height.
module stack_round_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned LIVES         = DEF_LIVES,
  parameter int unsigned MAX_HEIGHT    = DEF_MAX_HEIGHT,
  parameter int unsigned DROP_TIMEOUT  = DEF_DROP_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  stack_round_ctrl_if.slave bus
);

  localparam logic [1:0] LivesInit  = 2'(LIVES);
  localparam logic [6:0] HeightMax  = 7'(MAX_HEIGHT);
  localparam logic [7:0] DropLoad   = 8'(DROP_TIMEOUT - 1);
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  color_t     color_q, color_d;
  color_t     next_col_q, next_col_d;
  logic [1:0] lives_q, lives_d;
  logic [6:0] height_q, height_d;
  logic       win_q, win_d;
  logic       spawn_q, collision_q, game_over_q;

  logic       drop_load, drop_done, timeout;
  logic       settle_load, settle_done, settle_last_next;
  logic [7:0] drop_cnt, settle_cnt;
  logic       unused_drop_cnt;

  // Timeout counts tick pulses; it fires on the tick that arrives with the count exhausted.
  stack_timer #(.Width(8)) u_drop_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (drop_load),
    .load_val (DropLoad),
    .en       (bus.tick),
    .count    (drop_cnt),
    .done     (drop_done)
  );

  stack_timer #(.Width(8)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (SettleLoad),
    .en       (1'b1),
    .count    (settle_cnt),
    .done     (settle_done)
  );

  assign unused_drop_cnt = ^drop_cnt;
  assign timeout         = bus.tick && drop_done;
  assign settle_load     = (state_d == StSettle) && (state_q != StSettle);
  // Colour is registered, so the blank for the final settle cycle is decided one cycle early.
  assign settle_last_next = (state_q == StSettle) ? (settle_cnt == 8'd1)
                                                  : (SETTLE_CYCLES == 32'd1);

  always_comb begin
    state_d    = state_q;
    color_d    = color_q;
    next_col_d = next_col_q;
    lives_d    = lives_q;
    height_d   = height_q;
    win_d      = win_q;
    drop_load  = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          lives_d  = LivesInit;
          height_d = '0;
          win_d    = 1'b0;
          state_d  = StSpawn;
        end
      end
      StSpawn: state_d = StSwing;
      StSwing: begin
        if (bus.drop_btn) begin
          drop_load = 1'b1;
          state_d   = StDrop;
        end
      end
      StDrop: begin
        if (bus.land_hit) begin
          state_d = StScore;
          if (height_q < HeightMax) begin
            height_d = height_q + 7'd1;
          end
        end else if (bus.land_miss || timeout) begin
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          state_d = (lives_q <= 2'd1) ? StOver : StSettle;
        end
      end
      StScore: begin
        if (height_q >= HeightMax) begin
          win_d   = 1'b1;
          state_d = StOver;
        end else begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (settle_done) begin
          state_d = StSpawn;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StSpawn) && (state_q != StSpawn)) begin
      color_d    = next_col_q;
      next_col_d = rotate_color(next_col_q);
    end
    if ((state_d == StOver) || ((state_d == StSettle) && settle_last_next)) begin
      color_d = COL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      color_q     <= COL_NONE;
      next_col_q  <= COL_A;
      lives_q     <= LivesInit;
      height_q    <= '0;
      win_q       <= 1'b0;
      spawn_q     <= 1'b0;
      collision_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      next_col_q  <= next_col_d;
      lives_q     <= lives_d;
      height_q    <= height_d;
      win_q       <= win_d;
      spawn_q     <= (state_d == StSpawn);
      collision_q <= (state_d == StScore);
      game_over_q <= (state_d == StOver);
    end
  end

  assign bus.spawn     = spawn_q;
  assign bus.collision = collision_q;
  assign bus.color     = color_q;
  assign bus.lives     = lives_q;
  assign bus.height    = height_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_stack_round_ctrl.sv
// Randomized bench for stack_round_ctrl against a round-level game model.
module tb_stack_round_ctrl;
  import stack_pkg::*;

  localparam int Lives        = 3;
  localparam int MaxHeight    = 3;
  localparam int DropTimeout  = 5;
  localparam int SettleCycles = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_round_ctrl_if bus ();

  stack_round_ctrl #(
    .LIVES         (Lives),
    .MAX_HEIGHT    (MaxHeight),
    .DROP_TIMEOUT  (DropTimeout),
    .SETTLE_CYCLES (SettleCycles)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks     = 0;
  int failures   = 0;
  int n_spawn    = 0;
  int n_coll     = 0;
  int coll_color = 0;
  int prev_color = 0;

  // Game model: lives, height, win flag, next colour to issue, colour of the live block.
  int exp_lives  = Lives;
  int exp_height = 0;
  int exp_win    = 0;
  int exp_col    = int'(COL_A);
  int cur_col    = 0;
  bit over       = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.drop_btn  = 1'b0;
    bus.tick      = 1'b0;
    bus.land_hit  = 1'b0;
    bus.land_miss = 1'b0;
  endtask

  // One clock: inputs set beforehand are captured, outputs are sampled at the falling edge.
  task automatic cyc();
    prev_color = int'(bus.color);
    @(posedge clk);
    @(negedge clk);
    if (bus.spawn) n_spawn++;
    if (bus.collision) begin
      n_coll++;
      coll_color = int'(bus.color);
    end
  endtask

  task automatic junk_inputs();
    bus.drop_btn  = 1'($urandom_range(0, 1));
    bus.tick      = 1'($urandom_range(0, 1));
    bus.land_hit  = 1'($urandom_range(0, 1));
    bus.land_miss = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_spawn(input string tag, input int exp_gap);
    int gap = 0;
    int s0  = n_spawn;
    while ((n_spawn == s0) && (gap < 40)) begin
      cyc();
      gap++;
    end
    check_eq({tag, "_gap"}, gap, exp_gap);
    if (n_spawn != s0) begin
      check_eq({tag, "_color"}, int'(bus.color), exp_col);
      check_eq({tag, "_prev_color"}, prev_color, int'(COL_NONE));
      check_eq({tag, "_lives"}, int'(bus.lives), exp_lives);
      check_eq({tag, "_height"}, int'(bus.height), exp_height);
      check_eq({tag, "_win"}, int'(bus.win), 0);
      check_eq({tag, "_game_over"}, int'(bus.game_over), 0);
      cur_col = exp_col;
      exp_col = (exp_col == 3) ? 1 : exp_col + 1;
    end
  endtask

  task automatic new_game();
    exp_lives  = Lives;
    exp_height = 0;
    exp_win    = 0;
    over       = 1'b0;
    bus.start  = 1'b1;
    wait_spawn("start", 1);
    bus.start  = 1'b0;
  endtask

  // kind: 0 hit, 1 miss, 2 hit and miss together, 3 no landing (timeout)
  task automatic round(input int kind);
    int ticks = 0;
    int c0    = n_coll;
    int s0;
    int sw    = int'($urandom_range(1, 4));
    bit hit   = (kind == 0) || (kind == 2);
    for (int i = 0; i < sw; i++) begin
      junk_inputs();
      bus.drop_btn = 1'b0;
      bus.start    = 1'($urandom_range(0, 1));
      cyc();
    end
    clear_inputs();
    check_eq("swing_color", int'(bus.color), cur_col);
    check_eq("swing_no_coll", n_coll - c0, 0);
    bus.drop_btn = 1'b1;
    cyc();
    bus.drop_btn = 1'b0;
    if (kind == 3) begin
      for (int i = 0; (i < 64) && (ticks < DropTimeout); i++) begin
        bus.tick = 1'($urandom_range(0, 1));
        if (bus.tick) ticks++;
        if (ticks == DropTimeout) check_eq("pre_timeout_lives", int'(bus.lives), exp_lives);
        cyc();
      end
      bus.tick = 1'b0;
    end else begin
      int d = int'($urandom_range(0, 4));
      for (int i = 0; i < d; i++) begin
        bus.tick = (ticks < DropTimeout - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (bus.tick) ticks++;
        cyc();
      end
      bus.land_hit  = hit;
      bus.land_miss = (kind != 0);
      bus.tick      = 1'($urandom_range(0, 1));
      cyc();
      clear_inputs();
    end

    if (hit) begin
      if (exp_height < MaxHeight) exp_height++;
      check_eq("coll_count", n_coll - c0, 1);
      check_eq("coll_color", coll_color, cur_col);
      check_eq("score_height", int'(bus.height), exp_height);
      check_eq("score_lives", int'(bus.lives), exp_lives);
      if (exp_height == MaxHeight) begin
        exp_win = 1;
        over    = 1'b1;
      end else begin
        cyc();
        check_eq("settle_color", int'(bus.color), cur_col);
        check_eq("settle_no_coll", int'(bus.collision), 0);
      end
    end else begin
      if (exp_lives > 0) exp_lives--;
      check_eq("miss_coll_count", n_coll - c0, 0);
      check_eq("miss_lives", int'(bus.lives), exp_lives);
      over = (exp_lives == 0);
    end

    if (over) begin
      s0 = n_spawn;
      for (int i = 0; i < 6; i++) begin
        junk_inputs();
        cyc();
      end
      clear_inputs();
      check_eq("over_game_over", int'(bus.game_over), 1);
      check_eq("over_win", int'(bus.win), exp_win);
      check_eq("over_color", int'(bus.color), int'(COL_NONE));
      check_eq("over_lives", int'(bus.lives), exp_lives);
      check_eq("over_height", int'(bus.height), exp_height);
      check_eq("over_no_spawn", n_spawn - s0, 0);
      check_eq("over_coll_total", n_coll - c0, hit ? 1 : 0);
    end else begin
      wait_spawn("next", SettleCycles);
      check_eq("round_coll_total", n_coll - c0, hit ? 1 : 0);
    end
  endtask

  initial begin
    int s0;
    int c0;
    clear_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    check_eq("rst_lives", int'(bus.lives), Lives);
    check_eq("rst_height", int'(bus.height), 0);
    check_eq("rst_color", int'(bus.color), int'(COL_NONE));
    check_eq("rst_spawn", int'(bus.spawn), 0);
    check_eq("rst_collision", int'(bus.collision), 0);
    check_eq("rst_game_over", int'(bus.game_over), 0);
    check_eq("rst_win", int'(bus.win), 0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      junk_inputs();
      cyc();
    end
    clear_inputs();
    check_eq("idle_no_spawn", n_spawn, 0);
    check_eq("idle_no_coll", n_coll, 0);

    // Hit then three misses: lives 3->2->1->0, game lost.
    new_game();
    round(0);
    for (int i = 0; i < 3; i++) round(1);

    // Simultaneous hit/miss counts as a hit; three hits reach the height goal.
    new_game();
    round(2);
    round(0);
    round(0);

    // Two timeouts then a miss.
    new_game();
    round(3);
    round(3);
    round(1);

    for (int g = 0; g < 8; g++) begin
      new_game();
      for (int r = 0; (r < 10) && !over; r++) round(int'($urandom_range(0, 3)));
    end

    // Reset while a block is dropping.
    new_game();
    cyc();
    bus.drop_btn = 1'b1;
    cyc();
    bus.drop_btn = 1'b0;
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    s0 = n_spawn;
    c0 = n_coll;
    rst = 1'b0;
    bus.land_hit = 1'b1;
    cyc();
    rst = 1'b1;
    check_eq("drop_rst_color", int'(bus.color), int'(COL_NONE));
    check_eq("drop_rst_lives", int'(bus.lives), Lives);
    check_eq("drop_rst_height", int'(bus.height), 0);
    check_eq("drop_rst_collision", int'(bus.collision), 0);
    check_eq("drop_rst_game_over", int'(bus.game_over), 0);
    for (int i = 0; i < 4; i++) begin
      bus.land_miss = 1'($urandom_range(0, 1));
      cyc();
    end
    clear_inputs();
    check_eq("drop_rst_no_spawn", n_spawn - s0, 0);
    check_eq("drop_rst_no_coll", n_coll - c0, 0);
    check_eq("drop_rst_idle_color", int'(bus.color), int'(COL_NONE));

    exp_col = int'(COL_A);
    new_game();
    round(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
